uart_rx_fifo: RTL and testbench

Receive buffer stage directly downstream of uart_receiver_top. It captures each completed character (rsr_data plus its parity, frame and break status) on receive_load_en and stores it in a 16550-style RX FIFO, or in a single holding register when FIFOs are disabled. It presents RBR data and per-character status to the APB register file, and generates the data-ready, overrun, FIFO-error and trigger-level indications.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_rx_fifo_mem.sv | 24 ++
 rtl/uart_rx_fifo.sv | 128 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    // Canonical character width used by the receive path
    localparam int RX_DATA_W = 8;

    // One buffered character: status flags above the data byte
    typedef struct packed {
        logic                 bi;
        logic                 fe;
        logic                 pe;
        logic [RX_DATA_W-1:0] data;
    } rx_entry_t;

    // FCR[7:6] receive trigger encodings
    localparam logic [1:0] RX_TRIG_ONE  = 2'b00;
    localparam logic [1:0] RX_TRIG_QTR  = 2'b01;
    localparam logic [1:0] RX_TRIG_HALF = 2'b10;
    localparam logic [1:0] RX_TRIG_NEAR = 2'b11;

    // Occupancy at which the RDA indication fires for a given trigger select
    function automatic int unsigned rx_trig_threshold(input logic [1:0] trig,
                                                      input int unsigned depth);
        int unsigned thr;
        case (trig)
            RX_TRIG_ONE:  thr = 1;
            RX_TRIG_QTR:  thr = depth / 4;
            RX_TRIG_HALF: thr = depth / 2;
            default:      thr = depth - 2;
        endcase
        return thr;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// RX FIFO storage: register array with one write port and an async read port.
module uart_rx_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 11,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          pclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Storage is not reset; validity is tracked by the pointers in the parent
    always_ff @(posedge pclk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: 16550-style RX FIFO or single holding register,
// with head status, data-ready, overrun, FIFO-error and trigger outputs.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = RX_DATA_W
) (
    input  logic                       pclk,
    input  logic                       presetn,
    input  logic                       utrrst,
    input  logic                       fifo_en,
    input  logic                       rx_fifo_clr,
    input  logic [1:0]                 rx_trigger,
    input  logic [DATA_W-1:0]          rsr_data,
    input  logic                       parity_error,
    input  logic                       frame_error,
    input  logic                       uart_break,
    input  logic                       receive_load_en,
    input  logic                       rbr_read,
    input  logic                       lsr_read,
    output logic [DATA_W-1:0]          rbr_data,
    output logic                       top_pe,
    output logic                       top_fe,
    output logic                       top_bi,
    output logic                       data_ready,
    output logic                       overrun_error,
    output logic                       rx_fifo_error,
    output logic [$clog2(DEPTH):0]     rx_level,
    output logic                       trigger_reached
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Entry layout matches rx_entry_t: {bi, fe, pe, data}
    localparam int EW = DATA_W + 3;

    logic [AW-1:0] wr_ptr, rd_ptr, mem_waddr;
    logic [CW-1:0] count, err_cnt, cap, thr;
    logic          overrun, fifo_en_q;
    logic [EW-1:0] wr_entry, head_entry;
    logic          flush, full, rd_en, wr_en, ovw, ovr_set, mem_we;
    logic          new_err, head_err, err_inc, err_dec, has_data;

    // Any mode change empties the buffer, same as an explicit clear
    assign flush    = rx_fifo_clr | utrrst | (fifo_en ^ fifo_en_q);
    assign cap      = fifo_en ? CW'(DEPTH) : CW'(1);
    assign full     = (count >= cap);
    assign has_data = (count != '0);

    // A read frees a slot in the same cycle, so a full buffer still accepts a write
    assign rd_en    = rbr_read && has_data && !flush;
    assign wr_en    = receive_load_en && !flush && (!full || rd_en);
    assign ovr_set  = receive_load_en && !flush && full && !rd_en;
    // Holding-register mode keeps the newest character on overrun
    assign ovw      = ovr_set && !fifo_en;

    assign wr_entry  = {uart_break, frame_error, parity_error, rsr_data};
    assign mem_we    = wr_en | ovw;
    assign mem_waddr = ovw ? rd_ptr : wr_ptr;

    assign new_err  = parity_error | frame_error | uart_break;
    assign head_err = |head_entry[EW-1:EW-3];
    // An overwrite replaces the head: count its new status, drop its old one
    assign err_inc  = (wr_en | ovw) & new_err;
    assign err_dec  = (rd_en | ovw) & head_err;

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (EW),
        .AW    (AW)
    ) u_mem (
        .pclk  (pclk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head_entry)
    );

    // Pointer, occupancy and error-count bookkeeping
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_cnt <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_cnt <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count   <= count + CW'(wr_en) - CW'(rd_en);
            err_cnt <= err_cnt + CW'(err_inc) - CW'(err_dec);
        end
    end

    // Overrun is sticky until LSR read or receiver reset; a new event wins
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)                overrun <= 1'b0;
        else if (ovr_set)            overrun <= 1'b1;
        else if (lsr_read || utrrst) overrun <= 1'b0;
    end

    // Registered copy of the mode bit for change detection
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) fifo_en_q <= 1'b0;
        else          fifo_en_q <= fifo_en;
    end

    // Head view and status outputs, all zero when the buffer is empty
    always_comb begin
        thr = fifo_en ? CW'(rx_trig_threshold(rx_trigger, DEPTH)) : CW'(1);
        rbr_data        = has_data ? head_entry[DATA_W-1:0] : '0;
        top_pe          = has_data & head_entry[DATA_W];
        top_fe          = has_data & head_entry[DATA_W+1];
        top_bi          = has_data & head_entry[DATA_W+2];
        data_ready      = has_data;
        overrun_error   = overrun;
        rx_fifo_error   = fifo_en && (err_cnt != '0);
        rx_level        = count;
        trigger_reached = (count >= thr);
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with hand-computed expectations.
module tb_uart_rx_fifo;

    logic       pclk = 1'b0;
    logic       presetn, utrrst, fifo_en, rx_fifo_clr;
    logic [1:0] rx_trigger;
    logic [7:0] rsr_data;
    logic       parity_error, frame_error, uart_break;
    logic       receive_load_en, rbr_read, lsr_read;
    logic [7:0] rbr_data;
    logic       top_pe, top_fe, top_bi, data_ready, overrun_error, rx_fifo_error;
    logic [4:0] rx_level;
    logic       trigger_reached;

    int n_cmp = 0;
    int n_err = 0;

    always #5 pclk = ~pclk;

    uart_rx_fifo #(.DEPTH(16), .DATA_W(8)) dut (
        .pclk            (pclk),
        .presetn         (presetn),
        .utrrst          (utrrst),
        .fifo_en         (fifo_en),
        .rx_fifo_clr     (rx_fifo_clr),
        .rx_trigger      (rx_trigger),
        .rsr_data        (rsr_data),
        .parity_error    (parity_error),
        .frame_error     (frame_error),
        .uart_break      (uart_break),
        .receive_load_en (receive_load_en),
        .rbr_read        (rbr_read),
        .lsr_read        (lsr_read),
        .rbr_data        (rbr_data),
        .top_pe          (top_pe),
        .top_fe          (top_fe),
        .top_bi          (top_bi),
        .data_ready      (data_ready),
        .overrun_error   (overrun_error),
        .rx_fifo_error   (rx_fifo_error),
        .rx_level        (rx_level),
        .trigger_reached (trigger_reached)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic load(input logic [7:0] d, input logic pe, input logic fe, input logic bi);
        rsr_data = d; parity_error = pe; frame_error = fe; uart_break = bi;
        receive_load_en = 1'b1;
        tick();
        receive_load_en = 1'b0; parity_error = 1'b0; frame_error = 1'b0; uart_break = 1'b0;
    endtask

    task automatic rd();
        rbr_read = 1'b1;
        tick();
        rbr_read = 1'b0;
    endtask

    initial begin
        presetn = 1'b0; utrrst = 1'b0; fifo_en = 1'b1; rx_fifo_clr = 1'b0;
        rx_trigger = 2'b00; rsr_data = '0; parity_error = 1'b0; frame_error = 1'b0;
        uart_break = 1'b0; receive_load_en = 1'b0; rbr_read = 1'b0; lsr_read = 1'b0;

        // Reset state
        #22;
        chk("rst_rbr", rbr_data, 0);
        chk("rst_dr", data_ready, 0);
        chk("rst_lvl", rx_level, 0);
        chk("rst_oe", overrun_error, 0);
        chk("rst_fe", rx_fifo_error, 0);
        chk("rst_trig", trigger_reached, 0);
        presetn = 1'b1;
        tick(); tick();   // let the post-reset mode-change flush pass

        // Basic ordering, level and data_ready
        load(8'h41, 0, 0, 0);
        chk("t1_lvl1", rx_level, 1);
        chk("t1_dr1", data_ready, 1);
        load(8'h42, 0, 0, 0);
        chk("t1_lvl2", rx_level, 2);
        load(8'h43, 0, 0, 0);
        chk("t1_lvl3", rx_level, 3);
        chk("t1_rbr41", rbr_data, 8'h41);
        rd();
        chk("t1_lvl2r", rx_level, 2);
        chk("t1_rbr42", rbr_data, 8'h42);
        rd();
        chk("t1_lvl1r", rx_level, 1);
        chk("t1_rbr43", rbr_data, 8'h43);
        rd();
        chk("t1_lvl0", rx_level, 0);
        chk("t1_dr0", data_ready, 0);
        chk("t1_rbr0", rbr_data, 0);
        rd();   // read while empty is ignored
        chk("t1_empty_rd", rx_level, 0);

        // Fill to full at trigger 1/2, overrun on the 17th
        rx_trigger = 2'b10;
        for (int i = 0; i < 16; i++) begin
            load(8'h80 + 8'(i), 0, 0, 0);
            chk("t2_lvl", rx_level, i + 1);
            chk("t2_trig", trigger_reached, (i + 1 >= 8) ? 1 : 0);
        end
        chk("t2_oe_pre", overrun_error, 0);
        load(8'hFF, 0, 0, 0);
        chk("t2_lvl_full", rx_level, 16);
        chk("t2_oe", overrun_error, 1);
        chk("t2_head", rbr_data, 8'h80);
        lsr_read = 1'b1; tick(); lsr_read = 1'b0;
        chk("t2_oe_clr", overrun_error, 0);
        for (int i = 0; i < 16; i++) begin
            chk("t2_rdata", rbr_data, 8'h80 + i);
            rd();
        end
        chk("t2_lvl_end", rx_level, 0);
        chk("t2_trig_end", trigger_reached, 0);

        // Error status tracking
        rx_trigger = 2'b00;
        load(8'h55, 1, 0, 0);
        load(8'h00, 0, 1, 1);
        load(8'h10, 0, 0, 0);
        chk("t3_rxfe", rx_fifo_error, 1);
        chk("t3_rbr55", rbr_data, 8'h55);
        chk("t3_pe", top_pe, 1);
        chk("t3_trig", trigger_reached, 1);
        rd();
        chk("t3_rbr00", rbr_data, 8'h00);
        chk("t3_flags2", {top_bi, top_fe, top_pe}, 3'b110);
        chk("t3_rxfe2", rx_fifo_error, 1);
        rd();
        chk("t3_rxfe0", rx_fifo_error, 0);
        chk("t3_flags0", {top_bi, top_fe, top_pe}, 3'b000);
        chk("t3_rbr10", rbr_data, 8'h10);
        rd();
        chk("t3_lvl0", rx_level, 0);

        // Full FIFO with simultaneous read and write
        for (int i = 0; i < 16; i++) load(8'h20 + 8'(i), 0, 0, 0);
        rbr_read = 1'b1;
        load(8'h99, 0, 0, 0);
        rbr_read = 1'b0;
        chk("t5_lvl", rx_level, 16);
        chk("t5_oe", overrun_error, 0);
        for (int i = 1; i < 16; i++) begin
            chk("t5_rdata", rbr_data, 8'h20 + i);
            rd();
        end
        chk("t5_last", rbr_data, 8'h99);
        rd();
        chk("t5_lvl0", rx_level, 0);

        // Flush with a same-cycle load, then mode toggle
        for (int i = 0; i < 4; i++) load(8'h30 + 8'(i), 0, 0, 0);
        chk("t6_lvl4", rx_level, 4);
        rx_fifo_clr = 1'b1;
        load(8'h77, 0, 0, 0);
        rx_fifo_clr = 1'b0;
        chk("t6_clr_lvl", rx_level, 0);
        chk("t6_clr_dr", data_ready, 0);
        tick();
        chk("t6_clr_drop", rx_level, 0);
        load(8'h44, 0, 0, 0);
        chk("t6_lvl1", rx_level, 1);
        fifo_en = 1'b0;
        tick();
        chk("t6_tog_lvl", rx_level, 0);
        chk("t6_tog_dr", data_ready, 0);

        // Non-FIFO holding register overwrite
        load(8'h11, 0, 0, 0);
        chk("t4_rbr11", rbr_data, 8'h11);
        chk("t4_trig", trigger_reached, 1);
        load(8'h22, 1, 0, 0);
        chk("t4_rbr22", rbr_data, 8'h22);
        chk("t4_oe", overrun_error, 1);
        chk("t4_lvl", rx_level, 1);
        chk("t4_pe", top_pe, 1);
        chk("t4_rxfe", rx_fifo_error, 0);
        lsr_read = 1'b1; tick(); lsr_read = 1'b0;
        chk("t4_oe_clr", overrun_error, 0);
        rd();
        chk("t4_lvl0", rx_level, 0);
        load(8'h01, 0, 0, 0);
        load(8'h02, 0, 0, 0);
        chk("t4_oe2", overrun_error, 1);
        utrrst = 1'b1; tick(); utrrst = 1'b0;
        chk("t4_utr_oe", overrun_error, 0);
        chk("t4_utr_lvl", rx_level, 0);

        // Async reset in the middle of a write
        fifo_en = 1'b1;
        tick();
        load(8'h5A, 0, 0, 0);
        load(8'h5B, 1, 0, 0);
        chk("t7_lvl2", rx_level, 2);
        rsr_data = 8'h5C; receive_load_en = 1'b1;
        #2 presetn = 1'b0;
        #1;
        chk("t7_rbr", rbr_data, 0);
        chk("t7_dr", data_ready, 0);
        chk("t7_lvl", rx_level, 0);
        chk("t7_oe", overrun_error, 0);
        chk("t7_rxfe", rx_fifo_error, 0);
        chk("t7_trig", trigger_reached, 0);
        chk("t7_flags", {top_bi, top_fe, top_pe}, 0);
        receive_load_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
